fpga_rst_seq: RTL
=================

// Module: fpga_rst_seq
// PURPOSE
//  Board-level reset sequencer between the FPGA pads and the SoC. Conditions power-on
//  reset, a debounced push-button and a synchronous software request into NUM_CH
//  active-low reset outputs released in order (e.g. ch0 interconnect, ch1 uart/periph,
//  ch2 CPU core). Records the cause of the last reset for software/debug readout.
// PARAMETERS
//  NUM_CH      3      number of sequenced reset outputs, 1..8
//  DEB_W       16     width of debounce counter
//  DEB_CYCLES  50000  consecutive stable cycles needed to accept a button edge (< 2**DEB_W)
//  GAP_W       8      width of gap counter
//  GAP_CYCLES  16     cycles between successive channel releases (>=1, < 2**GAP_W)
// PORTS
//  sys_clk      in   1       single clock; all logic in this domain
//  sys_rst_n    in   1       asynchronous, active-low board/power-on reset
//  btn_rst_n    in   1       raw push-button, active-low, asynchronous, bouncy
//  sw_rst_req   in   1       synchronous one-cycle reset request (debug module / CSR)
//  rst_b_o      out  NUM_CH  registered active-low resets; bit i released i-th
//  seq_done     out  1       1 when all channels released (state RUN)
//  rst_cause    out  2       last cause: 00 power-on, 01 button, 10 software, 11 watchdog
// BEHAVIOUR
//  - sys_rst_n low: asynchronously rst_b_o=0, seq_done=0, rst_cause=00, state=HOLD,
//    counters=0, btn sync/debounced state = released (1). Internal release synchronised:
//    state machine starts 2 cycles after sys_rst_n rises (2-FF reset synchroniser).
//  - btn_rst_n: 2-FF synchroniser, then debouncer: debounced value changes only after
//    the synchronised input differs from it for DEB_CYCLES consecutive cycles; any
//    return resets the count. Debounced falling edge = button trigger.
//  - FSM (all outputs registered, changes visible one cycle after decision):
//    HOLD: all rst_b_o=0. Gap counter runs only while debounced button = 1; reaching
//      GAP_CYCLES-1 -> RELEASE with idx=0.
//    RELEASE: every GAP_CYCLES cycles set rst_b_o[idx]=1, idx++; first release occurs
//      on entry; after bit NUM_CH-1 set -> RUN. Bits never released out of order.
//    RUN: seq_done=1. Button trigger or sw_rst_req -> HOLD, all rst_b_o=0 and
//      seq_done=0 next cycle, rst_cause updated, gap counter cleared.
//  - Trigger in HOLD/RELEASE: return to/stay in HOLD, clear gap counter, drop any
//    already released bits, update rst_cause. Button and sw_rst_req same cycle: cause=01.
//  - Button held low: remain in HOLD indefinitely; sequence restarts after debounced release.
//  - sys_rst_n assertion mid-sequence overrides everything asynchronously, cause=00.
//  - Power-on to seq_done: 2 + GAP_CYCLES + (NUM_CH-1)*GAP_CYCLES + 1 cycles (power-on,
//    button idle); bench checks exact count.
// CONFIGURATION
//  FPGA_RST_WDT_EN defined: adds input wdt_kick (1, sync pulse) and parameter
//    WDT_CYCLES (default 2**20, 32-bit counter). In RUN, counter increments each cycle,
//    cleared by wdt_kick; reaching WDT_CYCLES-1 -> HOLD with rst_cause=11. Counter
//    held at 0 outside RUN. Priority of simultaneous causes: button > sw > watchdog.
//  Not defined: no wdt_kick port, no counter, rst_cause never 11.
// TESTING
//  1 Power-on: sys_rst_n 0->1, button high, NUM_CH=3, GAP=16 -> rst_b_o 000,001,011,111
//    at 16-cycle spacing; seq_done=1 at cycle 51; rst_cause=00.
//  2 Bounce: btn_rst_n toggles every 100 cycles for 2000 cycles (DEB_CYCLES=500) -> no
//    trigger; then held low 600 cycles -> rst_b_o=000 once, rst_cause=01, stays 000
//    until button high + 500 debounce + sequence.
//  3 sw_rst_req pulse in RUN -> next cycle rst_b_o=000, seq_done=0, cause=10; full
//    resequence; sw_rst_req during RELEASE after bit0 set -> bit0 dropped, restart.
//  4 Simultaneous debounced button and sw_rst_req -> cause=01; sys_rst_n low mid-
//    RELEASE -> outputs 0 same cycle (async), cause=00 after release.
//  5 FPGA_RST_WDT_EN, WDT_CYCLES=64: kick every 50 cycles -> no reset; stop kicking ->
//    reset exactly 64 cycles after last kick, cause=11; macro off -> port absent.

Source files
------------

// File: rtl/fpga_rst_seq.sv
// fpga_rst_seq: board reset sequencer releasing NUM_CH active-low resets in order.
// Optional watchdog is compiled in when FPGA_RST_WDT_EN is defined.
module fpga_rst_seq #(
  parameter int NUM_CH     = 3,
  parameter int DEB_W      = 16,
  parameter int DEB_CYCLES = 50000,
  parameter int GAP_W      = 8,
  parameter int GAP_CYCLES = 16
`ifdef FPGA_RST_WDT_EN
  ,parameter int WDT_CYCLES = 2**20
`endif
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              btn_rst_n,
  input  logic              sw_rst_req,
`ifdef FPGA_RST_WDT_EN
  input  logic              wdt_kick,
`endif
  output logic [NUM_CH-1:0] rst_b_o,
  output logic              seq_done,
  output logic [1:0]        rst_cause
);
  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;
  state_t            state_q;
  logic [1:0]        rsync_q, bsync_q, cause_q, cause_d;
  logic [DEB_W-1:0]  deb_cnt_q;
  logic [GAP_W-1:0]  gap_q;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic              deb_q, done_q, deb_flip, btn_trig, wdt_trig, trig, gap_last;

  assign deb_flip = (bsync_q[1] != deb_q) && (deb_cnt_q == DEB_W'(DEB_CYCLES - 1));
  assign btn_trig = deb_flip && deb_q;
  assign trig     = btn_trig || sw_rst_req || wdt_trig;
  assign cause_d  = btn_trig ? 2'b01 : sw_rst_req ? 2'b10 : 2'b11;
  assign gap_last = gap_q == GAP_W'(GAP_CYCLES - 1);
  assign rst_d    = (rst_q << 1) | NUM_CH'(1);

  // release synchroniser: the sequencer starts once both stages read high
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) rsync_q <= '0;
    else rsync_q <= {rsync_q[0], 1'b1};

  // button synchroniser and debouncer; count only while the input disagrees
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      bsync_q   <= 2'b11;
      deb_q     <= 1'b1;
      deb_cnt_q <= '0;
    end else begin
      bsync_q   <= {bsync_q[0], btn_rst_n};
      deb_q     <= deb_flip ? bsync_q[1] : deb_q;
      deb_cnt_q <= (bsync_q[1] == deb_q || deb_flip) ? '0 : deb_cnt_q + 1'b1;
    end

`ifdef FPGA_RST_WDT_EN
  logic [31:0] wdt_q;
  assign wdt_trig = (state_q == RUN) && (wdt_q == 32'(WDT_CYCLES - 1));
  // watchdog: counts unkicked RUN cycles, held at zero elsewhere
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) wdt_q <= '0;
    else wdt_q <= (state_q == RUN && !trig && !wdt_kick) ? wdt_q + 1'b1 : '0;
`else
  assign wdt_trig = 1'b0;
`endif

  // sequencer: hold, release one channel per gap (shifting ones in), then run
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q <= HOLD;
      rst_q   <= '0;
      done_q  <= 1'b0;
      cause_q <= 2'b00;
      gap_q   <= '0;
    end else if (rsync_q[1]) begin
      if (trig) begin
        state_q <= HOLD;
        rst_q   <= '0;
        done_q  <= 1'b0;
        cause_q <= cause_d;
        gap_q   <= '0;
      end else if (state_q == RUN) done_q <= 1'b1;
      else if (deb_q) begin
        gap_q <= gap_last ? '0 : gap_q + 1'b1;
        if (gap_last) begin
          rst_q   <= rst_d;
          state_q <= rst_d[NUM_CH-1] ? RUN : RELEASE;
        end
      end
    end

  assign rst_b_o   = rst_q;
  assign seq_done  = done_q;
  assign rst_cause = cause_q;
endmodule
